// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control: debounces start/lap buttons and sequences IDLE/RUN/PAUSE/LAP.
// Optional lap capture and display freeze are built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_start,
    input  logic        btn_lap,
    input  logic [23:0] cnt_bcd,
    output logic        count_en,
    output logic        count_clr,
    output logic [23:0] disp_bcd,
    output logic        disp_frozen,
    output logic [1:0]  state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    state_t state_q, state_next;

    logic [1:0]    btn_raw;
    logic [1:0]    sync1, sync2, deb, press;
    logic [CW-1:0] db_cnt [2];
    logic          start_p, lap_p;

    logic          count_en_d, count_clr_d, disp_frozen_d;
    logic [23:0]   disp_bcd_d;

`ifdef STOPWATCH_LAP_EN
    logic [23:0]   lap_reg;
    logic          capture;
`endif

    assign btn_raw = {btn_lap, btn_start};

    // Index 0 is start, index 1 is lap; a press pulse fires only when the debounced level flips high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            press <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                    press[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Start has priority: a simultaneous lap press is dropped.
    assign start_p = press[0];
    assign lap_p   = press[1] & ~press[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_en    <= 1'b0;
            count_clr   <= 1'b1;
            disp_frozen <= 1'b0;
            disp_bcd    <= '0;
`ifdef STOPWATCH_LAP_EN
            lap_reg     <= '0;
`endif
        end else begin
            state_q     <= state_next;
            count_en    <= count_en_d;
            count_clr   <= count_clr_d;
            disp_frozen <= disp_frozen_d;
            disp_bcd    <= disp_bcd_d;
`ifdef STOPWATCH_LAP_EN
            if (capture) lap_reg <= cnt_bcd;
`endif
        end
    end

    always_comb begin
        state_next = state_q;
`ifdef STOPWATCH_LAP_EN
        capture    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_p) state_next = RUN;
            end
            RUN: begin
                if (start_p) begin
                    state_next = PAUSE;
`ifdef STOPWATCH_LAP_EN
                end else if (lap_p) begin
                    state_next = LAP;
                    capture    = 1'b1;
`endif
                end
            end
            PAUSE: begin
                if (start_p)    state_next = RUN;
                else if (lap_p) state_next = IDLE;
            end
`ifdef STOPWATCH_LAP_EN
            LAP: begin
                if (start_p)    state_next = PAUSE;
                else if (lap_p) state_next = RUN;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they land on the same edge as the state change.
    always_comb begin
        count_en_d  = (state_next == RUN) || (state_next == LAP);
        count_clr_d = (state_q == PAUSE) && (state_next == IDLE);
`ifdef STOPWATCH_LAP_EN
        disp_frozen_d = (state_next == LAP);
        if (state_next == LAP) disp_bcd_d = capture ? cnt_bcd : lap_reg;
        else                   disp_bcd_d = cnt_bcd;
`else
        disp_frozen_d = 1'b0;
        disp_bcd_d    = cnt_bcd;
`endif
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4; expectations follow STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_start, btn_lap;
    logic [23:0] cnt_bcd;
    logic        count_en, count_clr, disp_frozen;
    logic [23:0] disp_bcd;
    logic [1:0]  state;

    typedef struct {
        int          cyc;
        string       name;
        logic [1:0]  st;
        logic        en;
        logic        clr;
        logic        frz;
        logic [23:0] disp;
        bit          chk_disp;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   flush = 1'b0;
    int   c0;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .btn_start(btn_start),
        .btn_lap(btn_lap),
        .cnt_bcd(cnt_bcd),
        .count_en(count_en),
        .count_clr(count_clr),
        .disp_bcd(disp_bcd),
        .disp_frozen(disp_frozen),
        .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expectAt(input int at, input string name, input logic [1:0] st,
                            input logic en, input logic clr, input logic frz,
                            input logic [23:0] disp, input bit chk_disp);
        exp_t e;
        e.cyc = at; e.name = name; e.st = st; e.en = en; e.clr = clr;
        e.frz = frz; e.disp = disp; e.chk_disp = chk_disp;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input bit s, input bit l, input int hold, input int settle);
        btn_start = s;
        btn_lap   = l;
        repeat (hold) @(negedge clk);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        repeat (settle) @(negedge clk);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (state !== e.st) begin
            errors++;
            $display("[TB] FAIL %s.state @%0d: got %0d want %0d", e.name, cyc, state, e.st);
        end
        checks++;
        if (count_en !== e.en) begin
            errors++;
            $display("[TB] FAIL %s.count_en @%0d: got %b want %b", e.name, cyc, count_en, e.en);
        end
        checks++;
        if (count_clr !== e.clr) begin
            errors++;
            $display("[TB] FAIL %s.count_clr @%0d: got %b want %b", e.name, cyc, count_clr, e.clr);
        end
        checks++;
        if (disp_frozen !== e.frz) begin
            errors++;
            $display("[TB] FAIL %s.disp_frozen @%0d: got %b want %b", e.name, cyc, disp_frozen, e.frz);
        end
        if (e.chk_disp) begin
            checks++;
            if (disp_bcd !== e.disp) begin
                errors++;
                $display("[TB] FAIL %s.disp_bcd @%0d: got %h want %h", e.name, cyc, disp_bcd, e.disp);
            end
        end
    endtask

    // Monitor: compares every expectation scheduled for the current cycle, away from the active edge.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checkOutput(sb[i]);
                sb.delete(i);
            end else if (sb[i].cyc < cyc || flush) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s.unsampled: got none want sample at cycle %0d", sb[i].name, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    initial begin
        reset = 1'b1; btn_start = 1'b0; btn_lap = 1'b0; cnt_bcd = 24'h000042;

        // Reset holds clr high and zeroes the display.
        @(negedge clk);
        expectAt(cyc + 1, "rst_a", 2'd0, 1'b0, 1'b1, 1'b0, 24'h0, 1'b1);
        expectAt(cyc + 2, "rst_b", 2'd0, 1'b0, 1'b1, 1'b0, 24'h0, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expectAt(cyc + 1, "rst_rel", 2'd0, 1'b0, 1'b0, 1'b0, 24'h000042, 1'b1);
        expectAt(cyc + 2, "rst_rel2", 2'd0, 1'b0, 1'b0, 1'b0, 24'h000042, 1'b1);
        repeat (3) @(negedge clk);

        // Two-cycle glitch is rejected.
        c0 = cyc;
        expectAt(c0 + 8,  "glitch_a", 2'd0, 1'b0, 1'b0, 1'b0, 24'h000042, 1'b1);
        expectAt(c0 + 12, "glitch_b", 2'd0, 1'b0, 1'b0, 1'b0, 24'h000042, 1'b1);
        applyStimulus(1'b1, 1'b0, 2, 12);

        // Held start: one transition exactly 7 edges after the press, release does nothing.
        c0 = cyc;
        expectAt(c0 + 6,  "start_pre",  2'd0, 1'b0, 1'b0, 1'b0, 24'h000042, 1'b1);
        expectAt(c0 + 7,  "start_run",  2'd1, 1'b1, 1'b0, 1'b0, 24'h000042, 1'b1);
        expectAt(c0 + 15, "start_held", 2'd1, 1'b1, 1'b0, 1'b0, 24'h000042, 1'b1);
        expectAt(c0 + 30, "start_rel",  2'd1, 1'b1, 1'b0, 1'b0, 24'h000042, 1'b1);
        applyStimulus(1'b1, 1'b0, 20, 12);

        // Lap in RUN: capture and freeze when built, ignored otherwise.
        cnt_bcd = 24'h000123;
        c0 = cyc;
        expectAt(c0 + 7, "lap_cap", LAP_EN ? 2'd3 : 2'd1, 1'b1, 1'b0, LAP_EN, 24'h000123, 1'b1);
        applyStimulus(1'b0, 1'b1, 8, 10);
        cnt_bcd = 24'h000130;
        expectAt(cyc + 2, "lap_hold", LAP_EN ? 2'd3 : 2'd1, 1'b1, 1'b0, LAP_EN,
                 LAP_EN ? 24'h000123 : 24'h000130, 1'b1);
        repeat (3) @(negedge clk);
        c0 = cyc;
        expectAt(c0 + 6, "lap2_pre", LAP_EN ? 2'd3 : 2'd1, 1'b1, 1'b0, LAP_EN,
                 LAP_EN ? 24'h000123 : 24'h000130, 1'b1);
        expectAt(c0 + 7, "lap2_run", 2'd1, 1'b1, 1'b0, 1'b0, 24'h000130, 1'b1);
        applyStimulus(1'b0, 1'b1, 8, 10);
        cnt_bcd = 24'h000131;
        expectAt(cyc + 1, "live_track", 2'd1, 1'b1, 1'b0, 1'b0, 24'h000131, 1'b1);
        repeat (2) @(negedge clk);

        // Pause, clear back to IDLE with a single clr pulse, then lap in IDLE is ignored.
        c0 = cyc;
        expectAt(c0 + 7, "pause", 2'd2, 1'b0, 1'b0, 1'b0, 24'h000131, 1'b1);
        applyStimulus(1'b1, 1'b0, 8, 10);
        c0 = cyc;
        expectAt(c0 + 6, "clr_pre",  2'd2, 1'b0, 1'b0, 1'b0, 24'h000131, 1'b1);
        expectAt(c0 + 7, "clr_hit",  2'd0, 1'b0, 1'b1, 1'b0, 24'h000131, 1'b1);
        expectAt(c0 + 8, "clr_post", 2'd0, 1'b0, 1'b0, 1'b0, 24'h000131, 1'b1);
        applyStimulus(1'b0, 1'b1, 8, 10);
        c0 = cyc;
        expectAt(c0 + 7, "idle_lap_a", 2'd0, 1'b0, 1'b0, 1'b0, 24'h000131, 1'b1);
        expectAt(c0 + 8, "idle_lap_b", 2'd0, 1'b0, 1'b0, 1'b0, 24'h000131, 1'b1);
        applyStimulus(1'b0, 1'b1, 8, 10);

        // Simultaneous start and lap in RUN: start wins, no capture.
        c0 = cyc;
        expectAt(c0 + 7, "run_again", 2'd1, 1'b1, 1'b0, 1'b0, 24'h000131, 1'b1);
        applyStimulus(1'b1, 1'b0, 8, 10);
        c0 = cyc;
        expectAt(c0 + 7,  "both_a", 2'd2, 1'b0, 1'b0, 1'b0, 24'h000131, 1'b1);
        expectAt(c0 + 12, "both_b", 2'd2, 1'b0, 1'b0, 1'b0, 24'h000131, 1'b1);
        applyStimulus(1'b1, 1'b1, 8, 10);

        // Reset mid-debounce with start held through release: full debounce again, one pulse.
        cnt_bcd   = 24'h000555;
        btn_start = 1'b1;
        c0 = cyc;
        expectAt(c0 + 5,  "mid_rst_a",  2'd0, 1'b0, 1'b1, 1'b0, 24'h0, 1'b1);
        expectAt(c0 + 6,  "mid_rst_b",  2'd0, 1'b0, 1'b1, 1'b0, 24'h0, 1'b1);
        expectAt(c0 + 7,  "mid_rel",    2'd0, 1'b0, 1'b0, 1'b0, 24'h000555, 1'b1);
        expectAt(c0 + 12, "held_pre",   2'd0, 1'b0, 1'b0, 1'b0, 24'h000555, 1'b1);
        expectAt(c0 + 13, "held_run",   2'd1, 1'b1, 1'b0, 1'b0, 24'h000555, 1'b1);
        expectAt(c0 + 20, "held_still", 2'd1, 1'b1, 1'b0, 1'b0, 24'h000555, 1'b1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (9) @(negedge clk);
        btn_start = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        flush = 1'b1;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Run-control sequencer for the stopwatch counter. Debounces the two front-panel buttons and runs the start/pause/lap/clear state machine. Drives the counter's count enable and clear. Selects live or lap-frozen BCD digits for the LCD driver. Sits between the raw button pins and the counter/LCD pair in the top level.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable clk samples required to accept a button level change (10 ms at 50 MHz); legal range 2..2^20.

Ports:
clk  input  1  system clock; single clock domain
reset  input  1  synchronous, active-high reset
btn_start  input  1  raw start/stop button; asynchronous, active-high
btn_lap  input  1  raw lap/clear button; asynchronous, active-high
cnt_bcd  input  24  live counter digits {H1,H0,M1,M0,S1,S0}, 4 bits each
count_en  output  1  counter advance enable
count_clr  output  1  counter clear; synchronous, 1-cycle pulse
disp_bcd  output  24  digits for the LCD driver, same packing as cnt_bcd
disp_frozen  output  1  1 = disp_bcd holds the captured lap value
state  output  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 LAP

Behaviour:
- Input synchronisation: each button passes through a 2-FF synchroniser.
- Debounce: per-button counter, ceil(log2(DEBOUNCE_CYCLES)) bits.
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is rejected.
- Press pulses: start_p and lap_p are 1-cycle pulses on the debounced rising edge. A held button yields exactly one pulse. Release produces no pulse.
- Latency: a sampled FSM transition updates all outputs on the next clk edge. All outputs are registered.
- FSM transitions:
  - IDLE: start_p -> RUN. lap_p ignored.
  - RUN: start_p -> PAUSE. lap_p -> LAP; cnt_bcd is captured into lap_reg in the same cycle.
  - LAP: start_p -> PAUSE, display unfreezes. lap_p -> RUN, display unfreezes. No re-capture.
  - PAUSE: start_p -> RUN. lap_p -> IDLE with count_clr=1 for exactly that transition cycle.
- Simultaneous start_p and lap_p: start_p wins and lap_p is discarded for that cycle.
- Output decode:
  - count_en = 1 in RUN and LAP, 0 in IDLE and PAUSE.
  - disp_frozen = 1 only in LAP.
  - disp_bcd = lap_reg when next state is LAP, else cnt_bcd, registered once. Live display therefore lags cnt_bcd by 1 cycle.
- Reset:
  - state=IDLE, count_en=0, count_clr=1, disp_frozen=0, disp_bcd=0, lap_reg=0.
  - Debounced levels and all counters = 0; synchroniser FFs = 0.
  - count_clr stays 1 while reset is high and falls on the first cycle after release.
  - Reset mid-debounce or mid-LAP aborts everything.
  - A button still held through reset release is accepted only after a full DEBOUNCE_CYCLES stable period, then generates one pulse.
- No wrap handling here: counter roll-over at 23:59:59 belongs to the counter. The controller passes digits unmodified, with no BCD arithmetic.

Optional Feature:
STOPWATCH_LAP_EN
- Defined:
  - Full behaviour as above.
- Undefined:
  - lap_reg, LAP state and freeze mux are not built.
  - In RUN, lap_p is ignored; in PAUSE, lap_p still clears the counter (-> IDLE).
  - disp_frozen is tied 0. disp_bcd is cnt_bcd registered once. state never equals 3.

Test Plan:
1. DEBOUNCE_CYCLES=4; reset 3 cycles then release -> count_clr=1 during reset, 0 after; state=0; disp_bcd=0.
2. btn_start high for 2 cycles only, then low -> no pulse; state stays 0. Then btn_start held 20 cycles -> exactly one transition to state=1 with count_en=1, 2 sync + 4 debounce + 1 cycles after the rising edge; release -> no change.
3. RUN with cnt_bcd=0x000123, press lap; cnt_bcd advances to 0x000130 -> state=3, disp_frozen=1, disp_bcd=0x000123, count_en=1. Press lap again -> state=1, disp_bcd tracks 0x000130 one cycle late.
4. RUN -> press start -> state=2, count_en=0. Press lap -> state=0, count_clr high exactly 1 cycle. Lap pressed again in IDLE -> no effect.
5. RUN with start and lap debounced-rising in the same cycle -> state=2; lap_reg unchanged; disp_frozen=0.
6. Build without STOPWATCH_LAP_EN: lap press in RUN -> state stays 1, disp_frozen=0. Lap press in PAUSE -> state=0 plus 1-cycle count_clr.
